sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Three-port arbiter sharing the single 32Mx16 SDRAM command port between the SD-card boot loader (write-only), the audio sample fetcher (read-only) and the video/sprite fetcher (read-only). It sits between the requesters and the SDRAM controller. It serialises single-word commands and latches the address and data of the winning port. It routes in-order read data back to the issuing port through a tag FIFO.

## Interface
Parameters:
- READ_DEPTH, 4: maximum outstanding (issued, not yet returned) reads; power of two, 2..16.
- STARVE_LIMIT, 8: consecutive audio grants after which a pending video request wins.

Ports:
- clk50  in  1  system clock; everything is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- p0_we  in  1  loader write request; held until p0_op_begun.
- p0_addr  in  25  loader word address.
- p0_wdata  in  16  loader write data.
- p0_op_begun  out  1  one-cycle accept pulse to the loader.
- p1_req / p2_req  in  1  audio / video read request; held until the matching op_begun.
- p1_addr / p2_addr  in  25  read word address.
- p1_op_begun / p2_op_begun  out  1  one-cycle accept pulse.
- p1_rvalid / p2_rvalid  out  1  read data valid for this port.
- p1_rdata / p2_rdata  out  16  read data; a copy of mem_rdata.
- mem_req  out  1  command valid to the SDRAM controller.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  25  latched command address.
- mem_wdata  out  16  latched write data.
- mem_op_begun  in  1  controller accepted the command (one-cycle pulse).
- mem_rvalid  in  1  read data returning, in issue order.
- mem_rdata  in  16  read data.
- rd_overflow_err  out  1  sticky: mem_rvalid arrived while the tag FIFO was empty.

## Operation
- FSM has two states: IDLE and BUSY.
- **IDLE, arbitration:**
  - Candidates are p1_req, p2_req and p0_we.
  - Reads are eligible only while outstanding < READ_DEPTH.
  - Priority is audio > video > loader.
  - Override: if starve_cnt ≥ STARVE_LIMIT and p2_req is pending, video wins.
- **On a win:**
  - Latch grant id, addr, wdata (loader only) and we (1 for p0, else 0).
  - Go to BUSY.
- **BUSY:**
  - mem_req = 1. mem_we, mem_addr and mem_wdata come from the latched registers.
  - Stay in BUSY until mem_op_begun.
  - pN_op_begun = mem_op_begun AND (grant == N), combinational in the same cycle.
  - On mem_op_begun:
    - For a read, push the grant id (1 or 2) into the tag FIFO.
    - Return to IDLE.
- **starve_cnt** (4 bits, saturating):
  - Increments on each audio grant made while p2_req is high.
  - Clears on any video grant, or when p2_req is low.
- **Read return:** on mem_rvalid, pop the FIFO head and assert prvalid on that port only.
- **outstanding counter:**
  - +1 on a read accept, −1 on mem_rvalid.
  - Both in the same cycle leaves it unchanged.
  - A simultaneous push and pop of the FIFO is legal, including when the FIFO is full: the pop frees a slot in that same cycle.
- **mem_rvalid with an empty FIFO:**
  - Set rd_overflow_err.
  - Assert no rvalid.
  - Leave the counter unchanged.

## Timing
- **Reset** (reset_n low at an edge):
  - State goes to IDLE.
  - mem_req, mem_we, all op_begun and rvalid outputs = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - FIFO emptied, outstanding = 0, starve_cnt = 0, rd_overflow_err = 0.
  - An in-flight command is abandoned; read data returned afterwards sets rd_overflow_err.
- **Grant latency:** a request seen in IDLE at edge k gives mem_req = 1 from cycle k+1.
- **Accept:** mem_op_begun in cycle m (including m = k+1) ends the command. State is IDLE in cycle m+1, with no mem_req.
  - A re-arbitration in IDLE during cycle m+1 puts the next mem_req in cycle m+2.
  - So there is at least one idle cycle between commands. This guarantees a requester that drops its request at m+1 is never double-granted.
- **Read data:** prdata and prvalid are combinational from mem_rdata and mem_rvalid, with zero added latency.
- **Requester contract:** inputs stay stable from the request until op_begun; the arbiter latches them at the grant.

## Test plan
- **Boot load:**
  - Stimulus: p0_we held with addr 0..3 and data 16'hA5A0..A5A3; controller acks 2 cycles after each mem_req.
  - Required: 4 writes with mem_we = 1, matching addr and data, and exactly 4 p0_op_begun pulses.
- **Priority:** p0, p1 and p2 all requesting in the same cycle. Required grant order: p1, then p2, then p0.
- **Starvation:**
  - Stimulus: p1 and p2 held continuously with immediate acks.
  - Required: p2 granted after exactly 8 p1 grants.
- **Read routing:**
  - Stimulus: issue p1@100, p2@200, p1@300; return rdata 1, 2, 3 in order.
  - Required: p1_rvalid with 1, p2_rvalid with 2, p1_rvalid with 3.
- **Depth limit:**
  - Stimulus: 4 reads accepted, no returns.
  - Required: a 5th p1_req gets no mem_req, while p0_we is still granted.
  - Then one mem_rvalid: the read issues in the following IDLE cycle.
- **Reset and error:**
  - Stimulus: assert reset_n = 0 in BUSY with 2 reads outstanding, then release.
  - Required: all outputs 0.
  - A later mem_rvalid sets rd_overflow_err and asserts no port rvalid.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM command port between the SD-card
// boot loader (p0, write-only), audio fetch (p1, read) and video fetch (p2, read).
//
// Ports:
//   clk50, reset_n          clock, synchronous active-low reset
//   p0_we/addr/wdata        loader write request, p0_op_begun accept pulse
//   p1_req/addr, p2_req/addr read requests, pN_op_begun accept pulses
//   p1/p2_rvalid, rdata     read data routed back to the issuing port
//   mem_req/we/addr/wdata   single-word command to the SDRAM controller
//   mem_op_begun            controller accepted the command
//   mem_rvalid/rdata        in-order read data from the controller
//   rd_overflow_err         sticky: read data arrived with no read pending
module sdram_port_arbiter #(
    parameter int READ_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_op_begun,
    input  logic        p1_req,
    input  logic [24:0] p1_addr,
    output logic        p1_op_begun,
    output logic        p1_rvalid,
    output logic [15:0] p1_rdata,
    input  logic        p2_req,
    input  logic [24:0] p2_addr,
    output logic        p2_op_begun,
    output logic        p2_rvalid,
    output logic [15:0] p2_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_op_begun,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        rd_overflow_err
);

    localparam int AW = $clog2(READ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(READ_DEPTH);
    localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

    localparam logic [1:0] GNT_P0 = 2'd0;
    localparam logic [1:0] GNT_P1 = 2'd1;
    localparam logic [1:0] GNT_P2 = 2'd2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [24:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [3:0]        starve_q, starve_d;
    logic [READ_DEPTH-1:0] tags_q, tags_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic       busy;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       head_is_p2;
    logic       rd_ok;
    logic       a_ok;
    logic       v_ok;
    logic       win_vld;
    logic [1:0] win_id;

    assign busy       = (state_q == BUSY);
    assign accept     = busy && mem_op_begun;
    assign push       = accept && !we_q;
    assign fifo_empty = (cnt_q == '0);
    assign pop        = mem_rvalid && !fifo_empty;
    assign head_is_p2 = tags_q[rptr_q];

    // Read eligibility uses the registered count only; a return in this
    // cycle frees the slot for the next IDLE cycle.
    assign rd_ok = (cnt_q < DEPTH_C);
    assign a_ok  = p1_req && rd_ok;
    assign v_ok  = p2_req && rd_ok;

    always_comb begin
        win_vld = 1'b1;
        win_id  = GNT_P0;
        if (v_ok && (starve_q >= LIMIT_C)) begin
            win_id = GNT_P2;
        end else if (a_ok) begin
            win_id = GNT_P1;
        end else if (v_ok) begin
            win_id = GNT_P2;
        end else if (p0_we) begin
            win_id = GNT_P0;
        end else begin
            win_vld = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    grant_d = win_id;
                    we_d    = (win_id == GNT_P0);
                    unique case (win_id)
                        GNT_P1:  addr_d = p1_addr;
                        GNT_P2:  addr_d = p2_addr;
                        default: begin
                            addr_d  = p0_addr;
                            wdata_d = p0_wdata;
                        end
                    endcase
                end
            end
            BUSY: begin
                if (mem_op_begun) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!p2_req) begin
            starve_d = '0;
        end else if (!busy && win_vld) begin
            if (win_id == GNT_P2) begin
                starve_d = '0;
            end else if (win_id == GNT_P1 && starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Tag FIFO: one bit per outstanding read, 1 = video.
    always_comb begin
        tags_d = tags_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (mem_rvalid && fifo_empty);
        if (push) begin
            tags_d[wptr_q] = (grant_q == GNT_P2);
            wptr_d         = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= GNT_P0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            starve_q <= '0;
            tags_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            starve_q <= starve_d;
            tags_q   <= tags_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign p0_op_begun = accept && (grant_q == GNT_P0);
    assign p1_op_begun = accept && (grant_q == GNT_P1);
    assign p2_op_begun = accept && (grant_q == GNT_P2);

    assign p1_rvalid = pop && !head_is_p2;
    assign p2_rvalid = pop && head_is_p2;
    assign p1_rdata  = mem_rdata;
    assign p2_rdata  = mem_rdata;

    assign rd_overflow_err = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed vectors and sequences for sdram_port_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sdram_port_arbiter;

    logic        clk50 = 1'b0;
    logic        reset_n;
    logic        p0_we;
    logic [24:0] p0_addr;
    logic [15:0] p0_wdata;
    logic        p0_op_begun;
    logic        p1_req;
    logic [24:0] p1_addr;
    logic        p1_op_begun;
    logic        p1_rvalid;
    logic [15:0] p1_rdata;
    logic        p2_req;
    logic [24:0] p2_addr;
    logic        p2_op_begun;
    logic        p2_rvalid;
    logic [15:0] p2_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_op_begun;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        rd_overflow_err;

    int n_vec = 0;
    int n_bad = 0;
    int p0_pulses = 0;

    always #5 clk50 = ~clk50;

    sdram_port_arbiter dut (
        .clk50           (clk50),
        .reset_n         (reset_n),
        .p0_we           (p0_we),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_op_begun     (p0_op_begun),
        .p1_req          (p1_req),
        .p1_addr         (p1_addr),
        .p1_op_begun     (p1_op_begun),
        .p1_rvalid       (p1_rvalid),
        .p1_rdata        (p1_rdata),
        .p2_req          (p2_req),
        .p2_addr         (p2_addr),
        .p2_op_begun     (p2_op_begun),
        .p2_rvalid       (p2_rvalid),
        .p2_rdata        (p2_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_op_begun    (mem_op_begun),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .rd_overflow_err (rd_overflow_err)
    );

    always @(negedge clk50) begin
        #2;
        if (p0_op_begun === 1'b1) p0_pulses++;
    end

    typedef struct {
        logic        rst_n;
        logic        we0;
        logic        r1;
        logic        r2;
        logic        ack;
        logic        rv;
        logic [15:0] rd;
        logic [7:0]  exp;
    } vec_t;

    function automatic logic [7:0] outs();
        return {mem_req, mem_we, p0_op_begun, p1_op_begun,
                p2_op_begun, p1_rvalid, p2_rvalid, rd_overflow_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm);
        logic got;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk50);
            #1;
            got = (mem_req === 1'b1);
        end
        chk(nm, {31'd0, got}, 32'd1);
    endtask

    task automatic issue(input int port, input logic [24:0] a);
        if (port == 1) begin
            p1_req  = 1'b1;
            p1_addr = a;
        end else begin
            p2_req  = 1'b1;
            p2_addr = a;
        end
        wait_req("issue_req");
        chk("issue_addr", {7'd0, mem_addr}, {7'd0, a});
        chk("issue_we", {31'd0, mem_we}, 32'd0);
        mem_op_begun = 1'b1;
        #1;
        if (port == 1) chk("issue_p1_ob", {31'd0, p1_op_begun}, 32'd1);
        else           chk("issue_p2_ob", {31'd0, p2_op_begun}, 32'd1);
        @(negedge clk50);
        mem_op_begun = 1'b0;
        p1_req       = 1'b0;
        p2_req       = 1'b0;
    endtask

    vec_t vt[13];

    initial begin
        int n1;
        int base;
        logic seen;
        logic prev;

        // mem_req, mem_we, p0/p1/p2_op_begun, p1/p2_rvalid, err
        vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'b0000_0000};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'b1001_0000};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'b0000_0000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'b1000_1000};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'b0000_0000};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'b1100_0000};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'b1110_0000};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 8'b0000_0100};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 8'b0000_0010};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3333, 8'b0000_0000};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'b0000_0001};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'b0000_0001};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'b0000_0000};

        reset_n      = 1'b0;
        p0_we        = 1'b0;
        p0_addr      = 25'h10;
        p0_wdata     = 16'hC0DE;
        p1_req       = 1'b0;
        p1_addr      = 25'h100;
        p2_req       = 1'b0;
        p2_addr      = 25'h200;
        mem_op_begun = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 16'h0;
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;

        // Priority, read routing, empty-FIFO error and reset, cycle by cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk50);
            reset_n      = vt[i].rst_n;
            p0_we        = vt[i].we0;
            p1_req       = vt[i].r1;
            p2_req       = vt[i].r2;
            mem_op_begun = vt[i].ack;
            mem_rvalid   = vt[i].rv;
            mem_rdata    = vt[i].rd;
            #1;
            chk($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, vt[i].exp});
            if (vt[i].rv && vt[i].exp[2])
                chk($sformatf("vec%0d_p1_rdata", i), {16'd0, p1_rdata}, {16'd0, vt[i].rd});
            if (vt[i].rv && vt[i].exp[1])
                chk($sformatf("vec%0d_p2_rdata", i), {16'd0, p2_rdata}, {16'd0, vt[i].rd});
        end
        mem_rdata = 16'h0;

        // Boot load: four writes, ack two cycles after mem_req.
        base = p0_pulses;
        for (int i = 0; i < 4; i++) begin
            p0_we    = 1'b1;
            p0_addr  = 25'(i);
            p0_wdata = 16'hA5A0 + 16'(i);
            wait_req("boot_req");
            chk("boot_we", {31'd0, mem_we}, 32'd1);
            chk("boot_addr", {7'd0, mem_addr}, i);
            chk("boot_wdata", {16'd0, mem_wdata}, 32'hA5A0 + i);
            @(negedge clk50);
            @(negedge clk50);
            mem_op_begun = 1'b1;
            #1;
            chk("boot_p0_ob", {31'd0, p0_op_begun}, 32'd1);
            @(negedge clk50);
            mem_op_begun = 1'b0;
        end
        p0_we = 1'b0;
        repeat (3) @(negedge clk50);
        chk("boot_pulses", p0_pulses - base, 32'd4);

        // Starvation: p1 and p2 held, immediate acks, each read returned.
        p1_req       = 1'b1;
        p2_req       = 1'b1;
        mem_op_begun = 1'b1;
        prev = 1'b0;
        seen = 1'b0;
        n1   = 0;
        for (int t = 0; t < 80 && !seen; t++) begin
            @(negedge clk50);
            mem_rvalid = prev;
            #1;
            prev = p1_op_begun | p2_op_begun;
            if (p2_op_begun) seen = 1'b1;
            else if (p1_op_begun) n1++;
        end
        @(negedge clk50);
        p1_req       = 1'b0;
        p2_req       = 1'b0;
        mem_op_begun = 1'b0;
        mem_rvalid   = prev;
        #1;
        chk("starve_p2_rvalid", {31'd0, p2_rvalid}, {31'd0, seen});
        @(negedge clk50);
        mem_rvalid = 1'b0;
        chk("starve_seen", {31'd0, seen}, 32'd1);
        chk("starve_p1_grants", n1, 32'd8);
        chk("starve_err", {31'd0, rd_overflow_err}, 32'd0);

        // Read routing: p1@100, p2@200, p1@300, data 1,2,3.
        issue(1, 25'd100);
        issue(2, 25'd200);
        issue(1, 25'd300);
        for (int i = 1; i <= 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'(i);
            #1;
            chk($sformatf("route%0d_rv", i), {30'd0, p2_rvalid, p1_rvalid},
                (i == 2) ? 32'd2 : 32'd1);
            chk($sformatf("route%0d_data", i),
                {16'd0, (i == 2) ? p2_rdata : p1_rdata}, i);
            @(negedge clk50);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;

        // Depth limit: four reads outstanding block a fifth, not the loader.
        for (int i = 0; i < 4; i++) issue(1, 25'h10 + 25'(i));
        p1_req  = 1'b1;
        p1_addr = 25'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            #1;
            chk("depth_block", {31'd0, mem_req}, 32'd0);
        end
        p0_we    = 1'b1;
        p0_addr  = 25'h77;
        p0_wdata = 16'hBEEF;
        wait_req("depth_p0_req");
        chk("depth_p0_we", {31'd0, mem_we}, 32'd1);
        chk("depth_p0_addr", {7'd0, mem_addr}, 32'h77);
        mem_op_begun = 1'b1;
        #1;
        chk("depth_p0_ob", {31'd0, p0_op_begun}, 32'd1);
        @(negedge clk50);
        mem_op_begun = 1'b0;
        p0_we        = 1'b0;
        mem_rvalid   = 1'b1;
        #1;
        chk("depth_pop_rv", {31'd0, p1_rvalid}, 32'd1);
        @(negedge clk50);
        mem_rvalid = 1'b0;
        #1;
        chk("depth_idle", {31'd0, mem_req}, 32'd0);
        @(negedge clk50);
        #1;
        chk("depth_issue", {31'd0, mem_req}, 32'd1);
        chk("depth_issue_addr", {7'd0, mem_addr}, 32'h55);
        mem_op_begun = 1'b1;
        @(negedge clk50);
        mem_op_begun = 1'b0;
        p1_req       = 1'b0;
        mem_rvalid   = 1'b1;
        @(negedge clk50);
        @(negedge clk50);
        mem_rvalid = 1'b0;

        // Reset while BUSY with two reads outstanding.
        p1_req  = 1'b1;
        p1_addr = 25'h66;
        wait_req("rst_busy");
        p1_req  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk50);
        reset_n = 1'b1;
        #1;
        chk("rst_outs", {24'd0, outs()}, 32'd0);
        chk("rst_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_rdata", {p1_rdata, p2_rdata}, 32'd0);
        @(negedge clk50);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
        #1;
        chk("err_no_rv", {30'd0, p2_rvalid, p1_rvalid}, 32'd0);
        @(negedge clk50);
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        #1;
        chk("err_set", {31'd0, rd_overflow_err}, 32'd1);
        chk("err_no_req", {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
